vga_frame_signature: RTL
========================

VGA_FRAME_SIGNATURE -- requirements
Module: vga_frame_signature

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameter COORD_W, default 10, width of the pixel coordinate inputs.
REQ-004 Parameter COLOR_W, default 8, width of each colour channel; 3*COLOR_W SHALL be at most 32.
REQ-005 Parameter FCOUNT_W, default 3, width of the frame counter.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  arms capture; low forces IDLE.
REQ-009 pixel_valid  input  1  pixel-clock enable qualifying coordinates and colour.
REQ-010 pixel_x, pixel_y  input  COORD_W each  current beam position.
REQ-011 vga_r, vga_g, vga_b  input  COLOR_W each  pixel colour.
REQ-012 expected_sig  input  32  reference signature for compare.
REQ-013 signature  output  32  last completed frame signature.
REQ-014 sig_valid  output  1  one-cycle pulse when signature updates.
REQ-015 frame_count  output  FCOUNT_W  completed frames, wrapping.
REQ-016 busy  output  1  high in ACCUM.
REQ-017 sync_err  output  1  sticky sync-error flag.
REQ-018 match  output  1  signature equals expected_sig, valid with sig_valid.
REQ-019 mismatch_count  output  8  saturating count of mismatching frames.

Function
REQ-020 A sample is accepted only in a cycle with pixel_valid high; all other cycles SHALL leave the state unchanged.
REQ-021 States: IDLE, WAIT_START, ACCUM, PUBLISH.
- IDLE -> WAIT_START when enable is high.
- Any state -> IDLE in the cycle enable is low, discarding the accumulator.
REQ-022 Frame start is a sample with x==0 and y==0.
- WAIT_START -> ACCUM on frame start.
- The accumulator SHALL be seeded with 32'hFFFFFFFF, then updated with that pixel.
REQ-023 Active pixel is a sample with x<H_ACTIVE and y<V_ACTIVE.
- Update: acc = rotate-left-1(acc) XOR zero-extended {r,g,b}, with r in the MSBs.
- The 32-bit pixel counter SHALL increment.
REQ-024 Frame end is a sample with x==0 and y==V_ACTIVE.
- ACCUM -> PUBLISH on frame end.
REQ-025 PUBLISH lasts exactly one clk cycle, then goes to WAIT_START. During it:
- signature <= acc.
- sig_valid is high.
- frame_count increments modulo 2^FCOUNT_W.
REQ-026 If the pixel counter does not equal H_ACTIVE*V_ACTIVE at frame end, the block SHALL still publish and SHALL set sync_err.
REQ-027 Frame start seen in ACCUM (no frame end in between):
- set sync_err;
- reseed the accumulator and clear the pixel counter;
- absorb the current pixel;
- stay in ACCUM and publish nothing.
REQ-028 Samples outside the active area that are not frame end SHALL be ignored.
REQ-029 Latency: signature and sig_valid SHALL be registered one clk cycle after the frame-end sample.
REQ-030 sync_err SHALL clear only on reset.

Reset
REQ-031 On reset assertion, the block SHALL immediately set:
- state=IDLE;
- signature=0, sig_valid=0, frame_count=0, busy=0;
- sync_err=0, match=0, mismatch_count=0;
- accumulator=32'hFFFFFFFF, pixel counter=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; capture resumes only at the next frame start after reset deasserts and enable is high.

Configuration
REQ-033 Macro FRAME_SIG_COMPARE_EN.
- Defined: during PUBLISH, match = (acc == expected_sig).
- Defined: on mismatch, mismatch_count increments and saturates at 255.
- Undefined: the compare logic SHALL be absent, match and mismatch_count tied to 0, and expected_sig ignored.

Verification
REQ-034 H_ACTIVE=4, V_ACTIVE=2, all pixels 0, full frame then (0,2) -> signature=32'hFFFFFFFF, sig_valid one cycle, frame_count=1, sync_err=0.
REQ-035 Same geometry, first pixel {r,g,b}=24'h000001, rest 0 -> signature=32'hFFFFFF7F.
REQ-036 Eight complete frames with FCOUNT_W=3 -> frame_count goes 1..7, then 0.
REQ-037 Frame start injected mid-frame -> sync_err=1, no sig_valid until the following complete frame, whose signature matches REQ-034.
REQ-038 reset asserted mid-frame, then one clean frame -> outputs zero immediately, and the first published signature equals the clean-frame value.
REQ-039 With FRAME_SIG_COMPARE_EN:
- expected_sig=32'hFFFFFFFF on the REQ-034 frame -> match=1, mismatch_count=0;
- expected_sig=0 on the same frame -> match=0, mismatch_count=1.

Source files
------------

// File: rtl/vga_frame_signature.sv
// Per-frame 32-bit rotate/XOR signature of the active area of a VGA pixel stream.
// Optional compare against expected_sig is built when FRAME_SIG_COMPARE_EN is defined.
module vga_frame_signature #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int COORD_W  = 10,
   parameter int COLOR_W  = 8,
   parameter int FCOUNT_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                pixel_valid,
   input  logic [COORD_W-1:0]  pixel_x,
   input  logic [COORD_W-1:0]  pixel_y,
   input  logic [COLOR_W-1:0]  vga_r,
   input  logic [COLOR_W-1:0]  vga_g,
   input  logic [COLOR_W-1:0]  vga_b,
   input  logic [31:0]         expected_sig,
   output logic [31:0]         signature,
   output logic                sig_valid,
   output logic [FCOUNT_W-1:0] frame_count,
   output logic                busy,
   output logic                sync_err,
   output logic                match,
   output logic [7:0]          mismatch_count,
   output logic [1:0]          dbg_state
);

   // Stream semantics: pixel_valid qualifies one sample per cycle and there is no
   // backpressure; sig_valid is a one-cycle pulse with signature/match stable from then on.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      ACCUM      = 2'd2,
      PUBLISH    = 2'd3
   } state_t;

   localparam logic [COORD_W-1:0] H_LIM     = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_LIM     = COORD_W'(V_ACTIVE);
   localparam logic [31:0]        PIX_TOTAL = 32'(H_ACTIVE * V_ACTIVE);
   localparam logic [31:0]        SEED      = 32'hFFFF_FFFF;

   state_t      state, next_state;
   logic [31:0] acc;
   logic [31:0] pix_cnt;
   logic [31:0] pix_word;
   logic        is_start, is_end, is_active;
   logic        clear, restart, absorb, publish, sync_set;

   assign pix_word  = 32'({vga_r, vga_g, vga_b});
   assign is_start  = (pixel_x == '0) && (pixel_y == '0);
   assign is_end    = (pixel_x == '0) && (pixel_y == V_LIM);
   assign is_active = (pixel_x < H_LIM) && (pixel_y < V_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      clear      = 1'b0;
      restart    = 1'b0;
      absorb     = 1'b0;
      publish    = 1'b0;
      sync_set   = 1'b0;
      if (!enable) begin
         next_state = IDLE;
         clear      = 1'b1;
      end else begin
         case (state)
            IDLE: next_state = WAIT_START;
            WAIT_START: begin
               if (pixel_valid && is_start) begin
                  next_state = ACCUM;
                  restart    = 1'b1;
               end
            end
            ACCUM: begin
               if (pixel_valid) begin
                  // A new frame start before the frame end means we lost sync.
                  if (is_start) begin
                     restart  = 1'b1;
                     sync_set = 1'b1;
                  end else if (is_end) begin
                     next_state = PUBLISH;
                     publish    = 1'b1;
                     sync_set   = (pix_cnt != PIX_TOTAL);
                  end else if (is_active) begin
                     absorb = 1'b1;
                  end
               end
            end
            PUBLISH: next_state = WAIT_START;
            default: next_state = IDLE;
         endcase
      end
   end

   // Outputs are loaded on the frame-end edge so they are visible during PUBLISH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc         <= SEED;
         pix_cnt     <= '0;
         signature   <= '0;
         sig_valid   <= 1'b0;
         frame_count <= '0;
         sync_err    <= 1'b0;
      end else begin
         sig_valid <= publish;
         if (clear) begin
            acc     <= SEED;
            pix_cnt <= '0;
         end else if (restart) begin
            acc     <= {SEED[30:0], SEED[31]} ^ pix_word;
            pix_cnt <= 32'd1;
         end else if (absorb) begin
            acc     <= {acc[30:0], acc[31]} ^ pix_word;
            pix_cnt <= pix_cnt + 32'd1;
         end
         if (publish) begin
            signature   <= acc;
            frame_count <= frame_count + FCOUNT_W'(1);
         end
         if (sync_set) sync_err <= 1'b1;
      end
   end

`ifdef FRAME_SIG_COMPARE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match          <= 1'b0;
         mismatch_count <= '0;
      end else if (publish) begin
         match <= (acc == expected_sig);
         if ((acc != expected_sig) && (mismatch_count != 8'hFF))
            mismatch_count <= mismatch_count + 8'd1;
      end
   end
`else
   logic unused_expected;
   assign unused_expected = ^expected_sig;
   assign match           = 1'b0;
   assign mismatch_count  = '0;
`endif

   assign busy      = (state == ACCUM);
   assign dbg_state = state;

endmodule
